// File: rtl/transpose_tile_scheduler_pkg.sv
// Shared types and constants for the transposed-convolution layer tile scheduler.
package transpose_tile_scheduler_pkg;

  localparam int unsigned DEF_NUM_PE    = 16;
  localparam int unsigned DEF_TIMEOUT_W = 12;
  localparam int unsigned ADDR_W        = 10;
  localparam int unsigned TILE_W        = 8;
  localparam int unsigned ITER_W        = 9;
  localparam int unsigned DONE_W        = 5;
  localparam int unsigned INSTR_W       = 8;

  localparam logic [INSTR_W-1:0] OPC_TRANSPOSE = 8'h03;
  localparam logic [DONE_W-1:0]  DONE_FULL     = DONE_W'(DEF_NUM_PE);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ISSUE    = 3'd1,
    ST_WAIT_RUN = 3'd2,
    ST_DRAIN    = 3'd3,
    ST_NEXT     = 3'd4,
    ST_FINISH   = 3'd5
  } state_e;

endpackage

// File: rtl/transpose_tile_scheduler_if.sv
// Job configuration, engine control and write-back handshake bundle.
interface transpose_tile_scheduler_if
  import transpose_tile_scheduler_pkg::*;
  ();

  logic                  cfg_valid;
  logic                  cfg_ready;
  logic [TILE_W-1:0]     cfg_num_tiles;
  logic [ITER_W-1:0]     cfg_num_iter;
  logic [ADDR_W-1:0]     cfg_ifmap_stride;
  logic [ADDR_W-1:0]     cfg_out_stride;
  logic                  eng_start;
  logic [INSTR_W-1:0]    eng_instr;
  logic [ITER_W-1:0]     eng_num_iter;
  logic [DONE_W-1:0]     eng_done;
  logic [ADDR_W-1:0]     ifmap_base;
  logic [ADDR_W-1:0]     out_base;
  logic                  wb_req;
  logic                  wb_ack;
  logic [TILE_W-1:0]     tile_idx;
  logic                  busy;
  logic                  layer_done;
  logic                  err_timeout;

  // Scheduler side
  modport master (
    input  cfg_valid, cfg_num_tiles, cfg_num_iter, cfg_ifmap_stride, cfg_out_stride,
    input  eng_done, wb_ack,
    output cfg_ready, eng_start, eng_instr, eng_num_iter, ifmap_base, out_base,
    output wb_req, tile_idx, busy, layer_done, err_timeout
  );

  // Host / engine / write-back side
  modport slave (
    output cfg_valid, cfg_num_tiles, cfg_num_iter, cfg_ifmap_stride, cfg_out_stride,
    output eng_done, wb_ack,
    input  cfg_ready, eng_start, eng_instr, eng_num_iter, ifmap_base, out_base,
    input  wb_req, tile_idx, busy, layer_done, err_timeout
  );

endinterface

// File: rtl/transpose_tile_scheduler_sched_watchdog.sv
// Cycle watchdog: counts enabled cycles since clear and flags the last allowed one.
module transpose_tile_scheduler_sched_watchdog #(
  parameter int unsigned TIMEOUT_W = 12
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire_c
);

  // Counter holds completed cycles, so the 2^W-1'th enabled cycle sees 2^W-2.
  localparam logic [TIMEOUT_W-1:0] LAST = TIMEOUT_W'((1 << TIMEOUT_W) - 2);

  logic [TIMEOUT_W-1:0] cnt_q, cnt_d;

  assign expire_c = en && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && !expire_c) begin
      cnt_d = cnt_q + TIMEOUT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/transpose_tile_scheduler.sv
// Layer-level sequencer: issues one engine run per tile, waits for completion,
// performs output write-back and steps the buffer bases.
module transpose_tile_scheduler
  import transpose_tile_scheduler_pkg::*;
#(
  parameter int unsigned NUM_PE    = DEF_NUM_PE,
  parameter int unsigned TIMEOUT_W = DEF_TIMEOUT_W
) (
  input  logic                        clk,
  input  logic                        rst,
  transpose_tile_scheduler_if.master  bus
);

  localparam logic [DONE_W-1:0] DONE_VAL = DONE_W'(NUM_PE);

  state_e state_q, state_d;

  logic [TILE_W-1:0]  tiles_q, tiles_d;
  logic [ITER_W-1:0]  iter_q, iter_d;
  logic [ADDR_W-1:0]  if_stride_q, if_stride_d;
  logic [ADDR_W-1:0]  out_stride_q, out_stride_d;
  logic [ADDR_W-1:0]  if_base_q, if_base_d;
  logic [ADDR_W-1:0]  out_base_q, out_base_d;
  logic [TILE_W-1:0]  tile_q, tile_d;
  logic               first_q, first_d;
  logic               err_q, err_d;

  logic               cfg_ready_q, cfg_ready_d;
  logic               busy_q, busy_d;
  logic               eng_start_q, eng_start_d;
  logic [INSTR_W-1:0] eng_instr_q, eng_instr_d;
  logic               wb_req_q, wb_req_d;
  logic               layer_done_q, layer_done_d;

  logic wd_expire_c;
  logic done_seen_c;
  logic last_tile_c;
  logic accept_c;

  assign accept_c    = (state_q == ST_IDLE) && bus.cfg_valid;
  // The first WAIT_RUN cycle may still see the previous tile's completion value.
  assign done_seen_c = !first_q && (bus.eng_done == DONE_VAL);
  assign last_tile_c = (tile_q == (tiles_q - TILE_W'(1)));

  transpose_tile_scheduler_sched_watchdog #(
    .TIMEOUT_W (TIMEOUT_W)
  ) u_watchdog (
    .clk      (clk),
    .rst      (rst),
    .clr      (state_q == ST_ISSUE),
    .en       (state_q == ST_WAIT_RUN),
    .expire_c (wd_expire_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept_c) state_d = (bus.cfg_num_tiles == '0) ? ST_FINISH : ST_ISSUE;
      end
      ST_ISSUE:    state_d = ST_WAIT_RUN;
      ST_WAIT_RUN: begin
        if (done_seen_c)      state_d = ST_DRAIN;
        else if (wd_expire_c) state_d = ST_IDLE;
      end
      ST_DRAIN: begin
        if (bus.wb_ack) state_d = ST_NEXT;
      end
      ST_NEXT:     state_d = last_tile_c ? ST_FINISH : ST_ISSUE;
      ST_FINISH:   state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they align with state_q.
  always_comb begin
    cfg_ready_d  = (state_d == ST_IDLE);
    busy_d       = (state_d != ST_IDLE);
    eng_start_d  = (state_d == ST_ISSUE);
    eng_instr_d  = (state_d == ST_ISSUE) ? OPC_TRANSPOSE : '0;
    wb_req_d     = (state_d == ST_DRAIN);
    layer_done_d = (state_d == ST_FINISH);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cfg_ready_q  <= 1'b1;
      busy_q       <= 1'b0;
      eng_start_q  <= 1'b0;
      eng_instr_q  <= '0;
      wb_req_q     <= 1'b0;
      layer_done_q <= 1'b0;
    end else begin
      cfg_ready_q  <= cfg_ready_d;
      busy_q       <= busy_d;
      eng_start_q  <= eng_start_d;
      eng_instr_q  <= eng_instr_d;
      wb_req_q     <= wb_req_d;
      layer_done_q <= layer_done_d;
    end
  end

  // Job latch, tile counter, base stepping and sticky timeout flag.
  always_comb begin
    tiles_d      = tiles_q;
    iter_d       = iter_q;
    if_stride_d  = if_stride_q;
    out_stride_d = out_stride_q;
    if_base_d    = if_base_q;
    out_base_d   = out_base_q;
    tile_d       = tile_q;
    err_d        = err_q;
    first_d      = (state_q == ST_ISSUE);

    if (accept_c) begin
      tiles_d      = bus.cfg_num_tiles;
      iter_d       = bus.cfg_num_iter;
      if_stride_d  = bus.cfg_ifmap_stride;
      out_stride_d = bus.cfg_out_stride;
      if_base_d    = '0;
      out_base_d   = '0;
      tile_d       = '0;
      err_d        = 1'b0;
    end

    if ((state_q == ST_WAIT_RUN) && !done_seen_c && wd_expire_c) begin
      err_d = 1'b1;
    end

    if ((state_q == ST_NEXT) && !last_tile_c) begin
      tile_d     = tile_q + TILE_W'(1);
      if_base_d  = if_base_q + if_stride_q;
      out_base_d = out_base_q + out_stride_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tiles_q      <= '0;
      iter_q       <= '0;
      if_stride_q  <= '0;
      out_stride_q <= '0;
      if_base_q    <= '0;
      out_base_q   <= '0;
      tile_q       <= '0;
      first_q      <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      tiles_q      <= tiles_d;
      iter_q       <= iter_d;
      if_stride_q  <= if_stride_d;
      out_stride_q <= out_stride_d;
      if_base_q    <= if_base_d;
      out_base_q   <= out_base_d;
      tile_q       <= tile_d;
      first_q      <= first_d;
      err_q        <= err_d;
    end
  end

  assign bus.cfg_ready    = cfg_ready_q;
  assign bus.busy         = busy_q;
  assign bus.eng_start    = eng_start_q;
  assign bus.eng_instr    = eng_instr_q;
  assign bus.eng_num_iter = iter_q;
  assign bus.wb_req       = wb_req_q;
  assign bus.layer_done   = layer_done_q;
  assign bus.ifmap_base   = if_base_q;
  assign bus.out_base     = out_base_q;
  assign bus.tile_idx     = tile_q;
  assign bus.err_timeout  = err_q;

endmodule

// File: tb/tb_transpose_tile_scheduler.sv
// Directed self-checking bench for transpose_tile_scheduler with a simple
// engine model and a write-back responder.
module tb_transpose_tile_scheduler;

  logic clk = 1'b0;
  logic rst = 1'b1;

  transpose_tile_scheduler_if bus ();

  transpose_tile_scheduler dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Engine model: 0 = done 45 cycles after start, 1 = done stuck at 16, 2 = never done
  int         eng_mode  = 0;
  int         eng_cnt   = 0;
  logic [4:0] eng_done_r = 5'd0;
  logic       ack_auto  = 1'b1;
  logic       ack_force = 1'b0;

  assign bus.eng_done = eng_done_r;
  assign bus.wb_ack   = ack_auto ? bus.wb_req : ack_force;

  always @(posedge clk) begin
    if (eng_mode == 1) begin
      eng_done_r <= 5'd16;
    end else if (eng_mode == 2) begin
      eng_done_r <= 5'd0;
    end else if (bus.eng_start) begin
      eng_cnt    <= 45;
      eng_done_r <= 5'd0;
    end else if (eng_cnt > 1) begin
      eng_cnt <= eng_cnt - 1;
    end else if (eng_cnt == 1) begin
      eng_cnt    <= 0;
      eng_done_r <= 5'd16;
    end
  end

  // Event recorder
  int         cyc = 0;
  int         n_start = 0, n_wb = 0, n_ack = 0, n_ld = 0;
  int         last_ack_cyc = 0, last_ld_cyc = 0;
  logic       wb_prev = 1'b0;
  logic [9:0] st_ifb   [16];
  logic [9:0] st_ofb   [16];
  logic [7:0] st_instr [16];
  logic [8:0] st_iter  [16];
  int         st_cyc   [16];
  int         wbr_cyc  [16];
  logic [9:0] ack_ofb  [16];
  logic [7:0] ack_tile [16];

  always @(posedge clk) begin
    cyc     <= cyc + 1;
    wb_prev <= bus.wb_req;
    if (bus.eng_start) begin
      st_ifb[n_start & 15]   <= bus.ifmap_base;
      st_ofb[n_start & 15]   <= bus.out_base;
      st_instr[n_start & 15] <= bus.eng_instr;
      st_iter[n_start & 15]  <= bus.eng_num_iter;
      st_cyc[n_start & 15]   <= cyc;
      n_start <= n_start + 1;
    end
    if (bus.wb_req && !wb_prev) begin
      wbr_cyc[n_wb & 15] <= cyc;
      n_wb <= n_wb + 1;
    end
    if (bus.wb_req && bus.wb_ack) begin
      ack_ofb[n_ack & 15]  <= bus.out_base;
      ack_tile[n_ack & 15] <= bus.tile_idx;
      last_ack_cyc <= cyc;
      n_ack <= n_ack + 1;
    end
    if (bus.layer_done) begin
      last_ld_cyc <= cyc;
      n_ld <= n_ld + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic [7:0] tiles, input logic [8:0] iter,
                        input logic [9:0] ifs, input logic [9:0] ofs);
    bus.cfg_num_tiles    = tiles;
    bus.cfg_num_iter     = iter;
    bus.cfg_ifmap_stride = ifs;
    bus.cfg_out_stride   = ofs;
    bus.cfg_valid        = 1'b1;
    tick();
    bus.cfg_valid        = 1'b0;
  endtask

  task automatic wait_ld(input string tag, input int base, input int budget);
    int k = 0;
    while (n_ld == base && k < budget) begin
      tick();
      k++;
    end
    check(tag, 32'(n_ld - base), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout observed=stuck expected=finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int s0, w0, a0, l0, k, bad;
    logic [9:0] ob0;

    bus.cfg_valid        = 1'b0;
    bus.cfg_num_tiles    = '0;
    bus.cfg_num_iter     = '0;
    bus.cfg_ifmap_stride = '0;
    bus.cfg_out_stride   = '0;

    // Reset values
    repeat (2) tick();
    check("rst_cfg_ready", 32'(bus.cfg_ready), 32'd1);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_eng_start", 32'(bus.eng_start), 32'd0);
    check("rst_eng_instr", 32'(bus.eng_instr), 32'd0);
    check("rst_wb_req", 32'(bus.wb_req), 32'd0);
    check("rst_layer_done", 32'(bus.layer_done), 32'd0);
    check("rst_err", 32'(bus.err_timeout), 32'd0);
    check("rst_bases", {12'd0, bus.ifmap_base, bus.out_base}, 32'd0);
    check("rst_tile_iter", {15'd0, bus.eng_num_iter, bus.tile_idx}, 32'd0);
    rst = 1'b0;
    tick();

    // Three-tile job, immediate write-back
    s0 = n_start; a0 = n_ack; l0 = n_ld;
    accept(8'd3, 9'd4, 10'h040, 10'h010);
    check("job3_busy", 32'(bus.busy), 32'd1);
    check("job3_cfg_ready", 32'(bus.cfg_ready), 32'd0);
    wait_ld("job3_done", l0, 400);
    check("job3_starts", 32'(n_start - s0), 32'd3);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("job3_instr%0d", i), 32'(st_instr[(s0 + i) & 15]), 32'h03);
      check($sformatf("job3_iter%0d", i), 32'(st_iter[(s0 + i) & 15]), 32'd4);
      check($sformatf("job3_ifb%0d", i), 32'(st_ifb[(s0 + i) & 15]), 32'(i * 32'h40));
      check($sformatf("job3_ofb%0d", i), 32'(st_ofb[(s0 + i) & 15]), 32'(i * 32'h10));
      check($sformatf("job3_ack_ofb%0d", i), 32'(ack_ofb[(a0 + i) & 15]), 32'(i * 32'h10));
      check($sformatf("job3_ack_tile%0d", i), 32'(ack_tile[(a0 + i) & 15]), 32'(i));
    end
    check("job3_acks", 32'(n_ack - a0), 32'd3);
    check("job3_ld_after_ack", 32'(last_ld_cyc > last_ack_cyc), 32'd1);
    tick();
    check("job3_single_ld", 32'(n_ld - l0), 32'd1);
    check("job3_idle_instr", 32'(bus.eng_instr), 32'd0);

    // Zero tiles: FINISH directly follows the accept edge
    s0 = n_start; w0 = n_wb; l0 = n_ld;
    accept(8'd0, 9'd7, 10'h011, 10'h022);
    check("zero_layer_done", 32'(bus.layer_done), 32'd1);
    tick();
    check("zero_ld_pulse", 32'(bus.layer_done), 32'd0);
    check("zero_idle", 32'(bus.cfg_ready), 32'd1);
    repeat (5) tick();
    check("zero_no_start", 32'(n_start - s0), 32'd0);
    check("zero_no_wb", 32'(n_wb - w0), 32'd0);
    check("zero_ld_count", 32'(n_ld - l0), 32'd1);

    // Stale done held at 16: ISSUE, two WAIT_RUN cycles, then DRAIN
    eng_mode = 1;
    tick();
    s0 = n_start; w0 = n_wb; l0 = n_ld;
    accept(8'd2, 9'd1, 10'h004, 10'h008);
    wait_ld("stale_done", l0, 100);
    check("stale_starts", 32'(n_start - s0), 32'd2);
    check("stale_gap0", 32'(wbr_cyc[w0 & 15] - st_cyc[s0 & 15]), 32'd3);
    check("stale_gap1", 32'(wbr_cyc[(w0 + 1) & 15] - st_cyc[(s0 + 1) & 15]), 32'd3);
    check("stale_start_gap", 32'(st_cyc[(s0 + 1) & 15] - st_cyc[s0 & 15]), 32'd5);
    eng_mode = 0;
    tick();

    // Write-back backpressure
    ack_auto = 1'b0; ack_force = 1'b0;
    l0 = n_ld;
    accept(8'd2, 9'd3, 10'h020, 10'h010);
    k = 0;
    while (!bus.wb_req && k < 200) begin
      tick();
      k++;
    end
    check("bp_reach_drain", 32'(bus.wb_req), 32'd1);
    ob0 = bus.out_base;
    s0  = n_start;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (!bus.wb_req || bus.out_base !== ob0 || n_start != s0) bad++;
    end
    check("bp_hold", 32'(bad), 32'd0);
    check("bp_out_base", 32'(ob0), 32'd0);
    ack_force = 1'b1;
    tick();
    ack_force = 1'b0;
    check("bp_wb_drop", 32'(bus.wb_req), 32'd0);
    tick();
    check("bp_resume_start", 32'(bus.eng_start), 32'd1);
    check("bp_resume_out_base", 32'(bus.out_base), 32'h010);
    check("bp_resume_tile", 32'(bus.tile_idx), 32'd1);
    ack_auto = 1'b1;
    wait_ld("bp_done", l0, 200);

    // Watchdog: engine never completes
    eng_mode = 2;
    tick();
    l0 = n_ld;
    accept(8'd1, 9'd5, 10'h001, 10'h001);
    k = 0;
    while (bus.busy && k < 5000) begin
      tick();
      k++;
    end
    check("to_cycles", 32'(k), 32'd4096);
    check("to_err", 32'(bus.err_timeout), 32'd1);
    check("to_cfg_ready", 32'(bus.cfg_ready), 32'd1);
    check("to_no_ld", 32'(n_ld - l0), 32'd0);
    repeat (3) tick();
    check("to_err_sticky", 32'(bus.err_timeout), 32'd1);
    eng_mode = 0;
    tick();

    // Next accept clears the error; ifmap base wraps modulo 2^10
    s0 = n_start; l0 = n_ld;
    accept(8'd3, 9'd2, 10'h300, 10'h100);
    check("wrap_err_clear", 32'(bus.err_timeout), 32'd0);
    wait_ld("wrap_done", l0, 400);
    check("wrap_ifb0", 32'(st_ifb[s0 & 15]), 32'h000);
    check("wrap_ifb1", 32'(st_ifb[(s0 + 1) & 15]), 32'h300);
    check("wrap_ifb2", 32'(st_ifb[(s0 + 2) & 15]), 32'h200);
    check("wrap_ofb2", 32'(st_ofb[(s0 + 2) & 15]), 32'h200);
    tick();

    // Asynchronous reset in the middle of WAIT_RUN
    s0 = n_start; w0 = n_wb; l0 = n_ld;
    accept(8'd2, 9'd4, 10'h040, 10'h010);
    tick();
    tick();
    check("mid_in_wait", 32'(bus.busy), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("arst_busy", 32'(bus.busy), 32'd0);
    check("arst_cfg_ready", 32'(bus.cfg_ready), 32'd1);
    check("arst_eng_start", 32'(bus.eng_start), 32'd0);
    check("arst_wb_req", 32'(bus.wb_req), 32'd0);
    check("arst_err", 32'(bus.err_timeout), 32'd0);
    check("arst_tile_base", {14'd0, bus.tile_idx, bus.ifmap_base}, 32'd0);
    repeat (3) tick();
    rst = 1'b0;
    repeat (80) tick();
    check("arst_no_more_start", 32'(n_start - s0), 32'd1);
    check("arst_no_wb", 32'(n_wb - w0), 32'd0);
    check("arst_no_ld", 32'(n_ld - l0), 32'd0);
    check("arst_still_idle", 32'(bus.cfg_ready), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
